// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM state type for the BCD-to-binary converter.
package bcd_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/ready/valid handshake and data bus of the converter.
interface bcd_to_bin_seq_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W = 14
);
    logic start;
    logic [DIGIT_W*DIGITS-1:0] bcd_in;
    logic ready;
    logic valid;
    logic [BIN_W-1:0] bin_out;
    logic ovf;
    logic err;
    modport master (output start, bcd_in, input ready, valid, bin_out, ovf, err);
    modport slave (input start, bcd_in, output ready, valid, bin_out, ovf, err);
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one-digit reverse double dabble correction, subtract 3 when >= 8.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    output logic [DIGIT_W-1:0] q_o
);
    assign q_o = (d_i >= ADJ_THRESH) ? d_i - DIGIT_W'(3) : d_i;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one result bit per clock.
// Defining BCD_DIGIT_CHECK_EN adds invalid-digit detection reported on err.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W = 14
)(
    input logic clk,
    input logic clr,
    bcd_to_bin_seq_if.slave bus
);
    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e state_q, state_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_shift, bcd_adj;
    logic [BIN_W-1:0] bin_q, bin_d, bin_shift, bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, err_q, err_d, ready_q, valid_q, bad_in;

    assign bcd_shift = bcd_q >> 1;
    assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i(bcd_shift[g*DIGIT_W +: DIGIT_W]),
            .q_o(bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic [DIGITS-1:0] bad;
    for (genvar g = 0; g < DIGITS; g++) begin : g_chk
        assign bad[g] = bus.bcd_in[g*DIGIT_W +: DIGIT_W] > BCD_MAX;
    end
    assign bad_in = |bad;
`else
    assign bad_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bcd_d = bcd_q;
        bin_d = bin_q;
        cnt_d = cnt_q;
        bout_d = bout_q;
        ovf_d = ovf_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                bcd_d = bus.bcd_in;
                bin_d = '0;
                cnt_d = '0;
                bout_d = '0;
                ovf_d = 1'b0;
                err_d = bad_in;
                state_d = bad_in ? DONE : SHIFT;
            end
            SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = bin_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                    bout_d = bin_shift;
                    ovf_d = |bcd_adj;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
            bout_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
            bout_q <= bout_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == DONE);
        end
    end

    assign bus.ready = ready_q;
    assign bus.valid = valid_q;
    assign bus.bin_out = bout_q;
    assign bus.ovf = ovf_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: table, hand-sequence and random checks of two converter configurations.
module tb_bcd_to_bin_seq;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) b16 ();
    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(8)) b8 ();

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut16 (.clk(clk), .clr(clr), .bus(b16));
    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) u_dut8 (.clk(clk), .clr(clr), .bus(b8));

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic ovf;
    } vec16_t;

    typedef struct {
        logic [11:0] bcd;
        logic [7:0] bin;
        logic ovf;
    } vec8_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint bcd_val(input logic [15:0] b, input int digits);
        longint v = 0;
        for (int i = digits - 1; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] rand_bcd(input int digits);
        logic [15:0] b = '0;
        for (int i = 0; i < digits; i++) b[i*4 +: 4] = 4'($urandom_range(9, 0));
        return b;
    endfunction

    task automatic run16(input logic [15:0] b, output logic [13:0] r, output logic o,
                         output logic e, output int lat);
        int n = 0;
        @(negedge clk);
        while (!b16.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        b16.bcd_in = b;
        b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        b16.bcd_in = 16'($urandom);
        lat = 0;
        while (!b16.valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = b16.bin_out;
        o = b16.ovf;
        e = b16.err;
        @(posedge clk);
        #1;
        check("valid16_pulse", {31'd0, b16.valid}, 32'd0);
    endtask

    task automatic run8(input logic [11:0] b, output logic [7:0] r, output logic o,
                        output logic e, output int lat);
        int n = 0;
        @(negedge clk);
        while (!b8.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        b8.bcd_in = b;
        b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        b8.bcd_in = 12'($urandom);
        lat = 0;
        while (!b8.valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = b8.bin_out;
        o = b8.ovf;
        e = b8.err;
        @(posedge clk);
        #1;
        check("valid8_pulse", {31'd0, b8.valid}, 32'd0);
    endtask

    initial begin
        vec16_t t16[6];
        vec8_t t8[4];
        logic [13:0] r16;
        logic [7:0] r8;
        logic o, e;
        int lat, k;
        longint v;

        t16[0] = '{16'h9999, 14'd9999, 1'b0};
        t16[1] = '{16'h0000, 14'd0, 1'b0};
        t16[2] = '{16'h0010, 14'd10, 1'b0};
        t16[3] = '{16'h0001, 14'd1, 1'b0};
        t16[4] = '{16'h0042, 14'd42, 1'b0};
        t16[5] = '{16'h1234, 14'd1234, 1'b0};
        t8[0] = '{12'h255, 8'd255, 1'b0};
        t8[1] = '{12'h256, 8'd0, 1'b1};
        t8[2] = '{12'h999, 8'hE7, 1'b1};
        t8[3] = '{12'h100, 8'd100, 1'b0};

        b16.start = 1'b0;
        b16.bcd_in = '0;
        b8.start = 1'b0;
        b8.bcd_in = '0;
        #12;
        check("rst_ready", {31'd0, b16.ready}, 32'd1);
        check("rst_valid", {31'd0, b16.valid}, 32'd0);
        check("rst_bin", {18'd0, b16.bin_out}, 32'd0);
        check("rst_ovf", {31'd0, b16.ovf}, 32'd0);
        check("rst_err", {31'd0, b16.err}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        foreach (t16[i]) begin
            run16(t16[i].bcd, r16, o, e, lat);
            check("tab16_bin", {18'd0, r16}, {18'd0, t16[i].bin});
            check("tab16_ovf", {31'd0, o}, {31'd0, t16[i].ovf});
            check("tab16_err", {31'd0, e}, 32'd0);
            check("tab16_lat", lat, 14);
        end
        check("held_bin", {18'd0, b16.bin_out}, 32'd1234);

        foreach (t8[i]) begin
            run8(t8[i].bcd, r8, o, e, lat);
            check("tab8_bin", {24'd0, r8}, {24'd0, t8[i].bin});
            check("tab8_ovf", {31'd0, o}, {31'd0, t8[i].ovf});
            check("tab8_lat", lat, 8);
        end

        // accept clears held result; async clear mid-shift at cnt=5
        @(negedge clk);
        b16.bcd_in = 16'h0777;
        b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        check("accept_ready", {31'd0, b16.ready}, 32'd0);
        check("accept_bin_clr", {18'd0, b16.bin_out}, 32'd0);
        repeat (5) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_ready", {31'd0, b16.ready}, 32'd1);
        check("clr_valid", {31'd0, b16.valid}, 32'd0);
        check("clr_bin", {18'd0, b16.bin_out}, 32'd0);
        check("clr_ovf", {31'd0, b16.ovf}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        run16(16'h0987, r16, o, e, lat);
        check("after_clr_bin", {18'd0, r16}, 32'd987);
        check("after_clr_lat", lat, 14);

        // start pulse during SHIFT is ignored
        @(negedge clk);
        b16.bcd_in = 16'h0555;
        b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        k = 0;
        repeat (3) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        b16.bcd_in = 16'h9999;
        b16.start = 1'b1;
        @(posedge clk);
        #1;
        k++;
        b16.start = 1'b0;
        while (!b16.valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("ign_lat", k, 14);
        check("ign_bin", {18'd0, b16.bin_out}, 32'd555);
        @(posedge clk);
        #1;
        check("ign_idle", {30'd0, b16.ready, b16.valid}, 32'd2);

        // start held high: back-to-back with one IDLE cycle between
        @(negedge clk);
        b16.bcd_in = 16'h1234;
        b16.start = 1'b1;
        k = 0;
        while (!b16.valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("b2b_bin1", {18'd0, b16.bin_out}, 32'd1234);
        b16.bcd_in = 16'h0042;
        k = 0;
        @(posedge clk);
        #1;
        k++;
        check("b2b_idle", {31'd0, b16.ready}, 32'd1);
        while (!b16.valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        b16.start = 1'b0;
        check("b2b_period", k, 16);
        check("b2b_bin2", {18'd0, b16.bin_out}, 32'd42);

`ifdef BCD_DIGIT_CHECK_EN
        run16(16'h12A4, r16, o, e, lat);
        check("chk_err", {31'd0, e}, 32'd1);
        check("chk_bin", {18'd0, r16}, 32'd0);
        check("chk_ovf", {31'd0, o}, 32'd0);
        check("chk_lat", lat, 0);
        run16(16'h1204, r16, o, e, lat);
        check("chk_ok_err", {31'd0, e}, 32'd0);
        check("chk_ok_bin", {18'd0, r16}, 32'd1204);
        check("chk_ok_lat", lat, 14);
`endif

        for (int i = 0; i < 30; i++) begin
            logic [15:0] b;
            b = rand_bcd(4);
            v = bcd_val(b, 4);
            run16(b, r16, o, e, lat);
            check("rnd16_bin", {18'd0, r16}, 32'(v % 16384));
            check("rnd16_ovf", {31'd0, o}, 32'(v >= 16384));
            b = rand_bcd(3);
            v = bcd_val(b, 3);
            run8(b[11:0], r8, o, e, lat);
            check("rnd8_bin", {24'd0, r8}, 32'(v % 256));
            check("rnd8_ovf", {31'd0, o}, 32'(v >= 256));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
